// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: sequential +4 fetch, taken-branch redirect with a fixed-length
// flush window, sticky misaligned-target trap and saturating branch statistics.
module pc_redirect_ctrl #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          FLUSH_CYCLES = 2,
   parameter int          CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall_i,
   input  logic             br_valid,
   input  logic             br_taken,
   input  logic [31:0]      br_pc,
   input  logic [31:0]      br_imm,
   output logic [31:0]      pc_o,
   output logic             pc_valid_o,
   output logic             flush_o,
   output logic             trap_o,
   output logic [31:0]      trap_addr_o,
   output logic [CNT_W-1:0] branch_cnt_o,
   output logic [CNT_W-1:0] taken_cnt_o
);

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH, S_TRAP} state_t;

   localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic             pc_valid_q, pc_valid_d;
   logic             flush_q, flush_d;
   logic             trap_q, trap_d;
   logic [31:0]      trap_addr_q, trap_addr_d;
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
   logic [3:0]       flush_cnt_q, flush_cnt_d;

   logic [31:0] target;
   logic [31:0] pc_seq;

   assign target = br_pc + br_imm;
   assign pc_seq = stall_i ? pc_q : pc_q + 32'd4;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pc_valid_d   = pc_valid_q;
      flush_d      = flush_q;
      trap_d       = trap_q;
      trap_addr_d  = trap_addr_q;
      branch_cnt_d = branch_cnt_q;
      taken_cnt_d  = taken_cnt_q;
      flush_cnt_d  = flush_cnt_q;

      unique case (state_q)
         S_BOOT: begin
            state_d    = S_RUN;
            pc_valid_d = 1'b1;
         end
         S_RUN: begin
            pc_d = pc_seq;
            if (br_valid) begin
               branch_cnt_d = sat_inc(branch_cnt_q);
               if (br_taken) begin
                  taken_cnt_d = sat_inc(taken_cnt_q);
                  if (target[1:0] != 2'b00) begin
                     state_d     = S_TRAP;
                     trap_d      = 1'b1;
                     trap_addr_d = target;
                     pc_valid_d  = 1'b0;
                     pc_d        = pc_q;
                  end else begin
                     // Redirect wins over a stall: the target must be fetched next.
                     state_d     = S_FLUSH;
                     pc_d        = target;
                     flush_d     = 1'b1;
                     flush_cnt_d = FLUSH_INIT;
                  end
               end
            end
         end
         S_FLUSH: begin
            // Wrong-path branches are ignored; the window length is stall-independent.
            pc_d = pc_seq;
            if (flush_cnt_q == 4'd0) begin
               flush_d = 1'b0;
               state_d = S_RUN;
            end else begin
               flush_cnt_d = flush_cnt_q - 4'd1;
            end
         end
         S_TRAP: begin
            pc_valid_d = 1'b0;
            flush_d    = 1'b0;
         end
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_BOOT;
         pc_q         <= RESET_PC;
         pc_valid_q   <= 1'b0;
         flush_q      <= 1'b0;
         trap_q       <= 1'b0;
         trap_addr_q  <= 32'd0;
         branch_cnt_q <= '0;
         taken_cnt_q  <= '0;
         flush_cnt_q  <= 4'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pc_valid_q   <= pc_valid_d;
         flush_q      <= flush_d;
         trap_q       <= trap_d;
         trap_addr_q  <= trap_addr_d;
         branch_cnt_q <= branch_cnt_d;
         taken_cnt_q  <= taken_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign pc_o         = pc_q;
   assign pc_valid_o   = pc_valid_q;
   assign flush_o      = flush_q;
   assign trap_o       = trap_q;
   assign trap_addr_o  = trap_addr_q;
   assign branch_cnt_o = branch_cnt_q;
   assign taken_cnt_o  = taken_cnt_q;

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Fetch-side consumer of the branch comparator's taken/not-taken result. It owns the architectural PC register and advances it by 4 each cycle. On a resolved taken branch it redirects the PC to br_pc + br_imm, flushes younger in-flight instructions for a fixed number of cycles, and traps on a misaligned target. It sits between the EX-stage branch comparator and the instruction-memory address port, and keeps saturating branch statistics counters.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FLUSH_CYCLES, 2, cycles flush_o is held high after a redirect; legal range 1..15.
CNT_W, 16, width of the statistics counters.

Ports:
clk  input  1  system clock, all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
stall_i  input  1  hazard stall; holds the PC while in RUN.
br_valid  input  1  a branch resolved in EX this cycle (the comparator enable).
br_taken  input  1  comparator result; only meaningful when br_valid=1.
br_pc  input  32  PC of the resolving branch.
br_imm  input  32  sign-extended B-type immediate.
pc_o  output  32  fetch address.
pc_valid_o  output  1  fetch request valid.
flush_o  output  1  squash the IF/ID and ID/EX contents.
trap_o  output  1  sticky misaligned-target trap.
trap_addr_o  output  32  offending target, captured on trap entry.
branch_cnt_o  output  CNT_W  count of accepted resolved branches.
taken_cnt_o  output  CNT_W  count of accepted taken branches.

Behaviour:
- Reset (async, rst_n=0):
  - pc_o=RESET_PC, pc_valid_o=0, flush_o=0, trap_o=0.
  - trap_addr_o=0, both counters=0, state=BOOT, flush counter=0.
- States: BOOT, RUN, FLUSH, TRAP. All outputs are registered.
- BOOT: on the first rising edge after rst_n=1, go to RUN and set pc_valid_o=1. pc_o stays at RESET_PC. br_valid is ignored in BOOT.
- RUN, target = br_pc + br_imm, computed modulo 2^32 with the carry dropped. Priority, highest first:
  - br_valid & br_taken & target[1:0]!=0:
    - go to TRAP; trap_o=1, trap_addr_o=target, pc_valid_o=0.
    - pc_o holds; branch_cnt and taken_cnt each +1.
  - br_valid & br_taken & aligned:
    - pc_o=target; flush_o=1; flush counter=FLUSH_CYCLES-1; go to FLUSH.
    - branch_cnt and taken_cnt each +1.
    - A redirect overrides stall_i.
  - br_valid & !br_taken: branch_cnt +1; the PC update follows the stall rule below.
  - PC update when not redirecting: stall_i=1 holds pc_o; stall_i=0 sets pc_o=pc_o+4 (wraps 32'hFFFF_FFFC -> 0).
- FLUSH:
  - flush_o stays 1 for exactly FLUSH_CYCLES cycles, starting the cycle after the redirect edge.
  - pc_valid_o stays 1; fetch at the target proceeds under normal stall rules, so pc_o advances by 4 when stall_i=0.
  - br_valid is ignored (wrong-path): no redirect, no counting.
  - The counter decrements every cycle regardless of stall_i. At 0, set flush_o=0 and go to RUN on that edge.
- TRAP:
  - Terminal until reset: pc_valid_o=0, flush_o=0, trap_o=1.
  - pc_o, trap_addr_o and the counters are frozen; all inputs are ignored.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-FLUSH or in TRAP clears everything immediately (asynchronously).
- Latency: br_valid sampled on edge N gives pc_o=target after edge N, and flush_o is high from edge N through edge N+FLUSH_CYCLES-1.

Test Plan:
1. Reset then free-run, stall_i=0, no branches -> one cycle in BOOT at pc_o=0, then pc_o 0,4,8,C on successive cycles; pc_valid_o=1 from the first edge after reset.
2. In RUN at pc_o=0x20: br_valid=1, br_taken=1, br_pc=0x18, br_imm=0x100 -> pc_o=0x118 next cycle; flush_o high exactly 2 cycles; pc_o then 0x11C, 0x120; taken_cnt=1, branch_cnt=1.
3. In RUN: stall_i=1 with br_valid=1, br_taken=0 -> pc_o holds; branch_cnt +1, taken_cnt unchanged. Then stall_i=1 with a taken branch to 0x40 -> pc_o=0x40 (redirect beats stall).
4. Second taken br_valid pulse during FLUSH -> ignored: pc_o keeps sequential +4, counters unchanged, flush_o drops on schedule.
5. Taken branch with br_pc=0x10, br_imm=0x6 -> trap_o=1, trap_addr_o=0x16, pc_valid_o=0, pc_o frozen. Later inputs have no effect; rst_n pulse returns to BOOT with pc_o=RESET_PC.
6. Wrap and saturation (CNT_W=4):
   - pc_o=0xFFFF_FFFC with no stall -> pc_o=0.
   - 17 not-taken branches -> branch_cnt_o=4'hF, taken_cnt_o=0.
   - br_pc=0xFFFF_FFF0, br_imm=0x20 taken -> pc_o=0x10.
